// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying an instruction word and its PC+2 between
// adjacent stages. Optional 2-entry skid buffer (SKID=1), synchronous flush,
// NOP injection while empty and a saturating bubble counter.
//
// Handshake: an input entry transfers on a rising edge where
// in_valid & in_ready (acc); an output entry transfers on a rising edge where
// out_valid & out_ready (take). in_valid/out_valid must not depend on the
// partner's ready. With SKID=1 in_ready is a pure decode of the state
// register; with SKID=0 in_ready = out_ready | !out_valid.
module pipe_stage_reg #(
  parameter int                 INSTR_W  = 16,
  parameter int                 PC_W     = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = 16'h0800,
  parameter bit                 SKID     = 1'b1,
  parameter int                 CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               acc;
  logic               take;

  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  // The main entry is visible only while valid; otherwise drive a NOP bubble.
  assign out_instr = out_valid ? main_instr : NOP_WORD;
  assign out_pc    = out_valid ? main_pc : '0;

  generate
    if (SKID) begin : g_skid
      // Ready depends only on the state register, so no out_ready path.
      assign in_ready = (state != TWO);
    end else begin : g_no_skid
      // Single entry: accept when empty or when the entry leaves this cycle.
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  // Occupancy FSM and data registers; flush overrides every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      main_instr <= '0;
      main_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state      <= ONE;
            main_instr <= in_instr;
            main_pc    <= in_pc;
          end
        end
        ONE: begin
          if (acc && take) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
          end else if (acc && SKID) begin
            state      <= TWO;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
          end else if (take) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            state      <= ONE;
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Count cycles where downstream was ready but got a bubble; saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!out_valid && out_ready && !flush && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance a (SKID=1, 4-bit counter) and
// instance b (SKID=0, 16-bit counter), checked against a queue-based model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- instance a: SKID=1 ----------------
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [15:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc;
  logic [3:0]  a_bubble_cnt;

  pipe_stage_reg #(.INSTR_W(16), .PC_W(16), .NOP_WORD(16'h0800), .SKID(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
    .out_pc(a_out_pc), .bubble_cnt(a_bubble_cnt)
  );

  // ---------------- instance b: SKID=0 ----------------
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [15:0] b_in_instr, b_in_pc, b_out_instr, b_out_pc;
  logic [15:0] b_bubble_cnt;

  pipe_stage_reg #(.INSTR_W(16), .PC_W(16), .NOP_WORD(16'h0800), .SKID(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
    .out_pc(b_out_pc), .bubble_cnt(b_bubble_cnt)
  );

  // ---------------- reference model ----------------
  // Each queue holds the {instr, pc} entries the stage currently owns, oldest first.
  logic [31:0] qa[$];
  logic [31:0] exp_q[$];
  int          bub_a = 0;
  int          bub_b = 0;
  int          b_emitted = 0;
  int          b_accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic v, input logic [15:0] i, input logic [15:0] p,
                         input logic r, input logic f);
    @(negedge clk);
    a_in_valid = v; a_in_instr = i; a_in_pc = p; a_out_ready = r; a_flush = f;
    #1;
  endtask

  task automatic check_a();
    logic        ov;
    ov = (qa.size() > 0);
    chk("a_out_valid", a_out_valid, ov);
    chk("a_in_ready", a_in_ready, qa.size() < 2);
    chk("a_out_instr", a_out_instr, ov ? qa[0][31:16] : 16'h0800);
    chk("a_out_pc", a_out_pc, ov ? qa[0][15:0] : 16'h0000);
    chk("a_bubble_cnt", a_bubble_cnt, bub_a);
  endtask

  task automatic clock_a();
    logic acc, take, empty;
    @(posedge clk);
    empty = (qa.size() == 0);
    acc   = a_in_valid && (qa.size() < 2);
    take  = !empty && a_out_ready;
    if (a_flush) qa.delete();
    else begin
      if (take) void'(qa.pop_front());
      if (acc) qa.push_back({a_in_instr, a_in_pc});
    end
    if (empty && a_out_ready && !a_flush && bub_a < 15) bub_a++;
  endtask

  task automatic drive_b(input logic v, input logic [15:0] i, input logic [15:0] p,
                         input logic r, input logic f);
    @(negedge clk);
    b_in_valid = v; b_in_instr = i; b_in_pc = p; b_out_ready = r; b_flush = f;
    #1;
  endtask

  task automatic check_b();
    logic ov;
    ov = (exp_q.size() > 0);
    chk("b_out_valid", b_out_valid, ov);
    chk("b_in_ready", b_in_ready, b_out_ready || !ov);
    chk("b_out_instr", b_out_instr, ov ? exp_q[0][31:16] : 16'h0800);
    chk("b_out_pc", b_out_pc, ov ? exp_q[0][15:0] : 16'h0000);
    chk("b_bubble_cnt", b_bubble_cnt, bub_b);
    if (b_out_valid && b_out_ready && !b_flush) b_emitted++;
  endtask

  task automatic clock_b();
    logic acc, take, empty;
    @(posedge clk);
    empty = (exp_q.size() == 0);
    take  = !empty && b_out_ready;
    acc   = b_in_valid && (b_out_ready || empty);
    if (b_flush) exp_q.delete();
    else begin
      if (take) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({b_in_instr, b_in_pc});
        b_accepted++;
      end
    end
    if (empty && b_out_ready && !b_flush && bub_b < 65535) bub_b++;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [15:0] e_oi;
    logic [15:0] e_pc;
    logic        e_ir;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // stream three entries at full throughput
    tbl[0]  = '{1'b1, 16'h1111, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    tbl[1]  = '{1'b1, 16'h2222, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h0002, 1'b1};
    tbl[2]  = '{1'b1, 16'h3333, 16'h0006, 1'b1, 1'b0, 1'b1, 16'h2222, 16'h0004, 1'b1};
    tbl[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3333, 16'h0006, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    // stall into TWO, then release
    tbl[5]  = '{1'b1, 16'hA001, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    tbl[6]  = '{1'b1, 16'hA002, 16'h0012, 1'b0, 1'b0, 1'b1, 16'hA001, 16'h0010, 1'b1};
    tbl[7]  = '{1'b1, 16'hA003, 16'h0014, 1'b0, 1'b0, 1'b1, 16'hA001, 16'h0010, 1'b0};
    tbl[8]  = '{1'b1, 16'hA003, 16'h0014, 1'b0, 1'b0, 1'b1, 16'hA001, 16'h0010, 1'b0};
    tbl[9]  = '{1'b1, 16'hA003, 16'h0014, 1'b1, 1'b0, 1'b1, 16'hA001, 16'h0010, 1'b0};
    tbl[10] = '{1'b1, 16'hA003, 16'h0014, 1'b1, 1'b0, 1'b1, 16'hA002, 16'h0012, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA003, 16'h0014, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    // flush in TWO with a live input, then flush with an accepted input
    tbl[13] = '{1'b1, 16'hB001, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    tbl[14] = '{1'b1, 16'hB002, 16'h0022, 1'b0, 1'b0, 1'b1, 16'hB001, 16'h0020, 1'b1};
    tbl[15] = '{1'b1, 16'hB003, 16'h0024, 1'b0, 1'b1, 1'b1, 16'hB001, 16'h0020, 1'b0};
    tbl[16] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};
    tbl[17] = '{1'b1, 16'hB004, 16'h0026, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b1};
    tbl[18] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 1'b1};

    a_in_valid = 0; a_in_instr = 0; a_in_pc = 0; a_out_ready = 0; a_flush = 0;
    b_in_valid = 0; b_in_instr = 0; b_in_pc = 0; b_out_ready = 0; b_flush = 0;

    // reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_instr", a_out_instr, 16'h0800);
    chk("rst_out_pc", a_out_pc, 16'h0000);
    chk("rst_bubble_cnt", a_bubble_cnt, 4'd0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // directed table on instance a
    for (int k = 0; k < 19; k++) begin
      drive_a(tbl[k].v, tbl[k].instr, tbl[k].pc, tbl[k].ordy, tbl[k].fl);
      chk($sformatf("tbl%0d_out_valid", k), a_out_valid, tbl[k].e_ov);
      chk($sformatf("tbl%0d_out_instr", k), a_out_instr, tbl[k].e_oi);
      chk($sformatf("tbl%0d_out_pc", k), a_out_pc, tbl[k].e_pc);
      chk($sformatf("tbl%0d_in_ready", k), a_in_ready, tbl[k].e_ir);
      check_a();
      clock_a();
    end

    // asynchronous reset while holding one entry
    drive_a(1'b1, 16'hC001, 16'h0030, 1'b0, 1'b0);
    check_a();
    clock_a();
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 0;
    #1;
    chk("one_out_valid", a_out_valid, 1'b1);
    chk("one_out_instr", a_out_instr, 16'hC001);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", a_out_valid, 1'b0);
    chk("arst_out_instr", a_out_instr, 16'h0800);
    chk("arst_out_pc", a_out_pc, 16'h0000);
    chk("arst_bubble_cnt", a_bubble_cnt, 4'd0);
    chk("arst_in_ready", a_in_ready, 1'b1);
    qa.delete(); bub_a = 0;
    exp_q.delete(); bub_b = 0;
    #1 rst = 1'b0;
    clock_a();

    // bubble counter saturation (4-bit)
    for (int k = 0; k < 20; k++) begin
      drive_a(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      check_a();
      clock_a();
    end
    #1 chk("bubble_sat", a_bubble_cnt, 4'd15);
    for (int k = 0; k < 3; k++) begin
      drive_a(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      check_a();
      clock_a();
    end
    #1 chk("bubble_hold", a_bubble_cnt, 4'd15);

    // randomized traffic on instance a
    for (int k = 0; k < 300; k++) begin
      drive_a(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      check_a();
      clock_a();
    end
    drive_a(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // instance b: out_ready toggling with constant in_valid
    b_emitted = 0; b_accepted = 0;
    for (int k = 0; k < 12; k++) begin
      drive_b(1'b1, 16'hD000 + 16'(k), 16'h0040 + 16'(2 * k), 1'((k % 2) == 0), 1'b0);
      check_b();
      clock_b();
    end
    for (int k = 0; k < 3; k++) begin
      drive_b(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      check_b();
      clock_b();
    end
    chk("b_emitted_once", b_emitted, b_accepted);
    chk("b_accepted_cnt", b_accepted, 6);

    // randomized traffic on instance b
    for (int k = 0; k < 200; k++) begin
      drive_b(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      check_b();
      clock_b();
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
